// File: rtl/maze_pkg.sv
// Shared types for the maze job scheduler: FSM states, maze size, direction codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package maze_pkg;

    // 17x17 map streamed row-major, one bit per beat
    localparam int MAZE_BITS_DEF = 289;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // solver direction code, forwarded to the requester untouched
    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

endpackage

// File: rtl/maze_job_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the rr pointer, wrapping.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; en=0 forces an empty grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt_next,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int ID_W = $clog2(NUM_REQ);

    // scan requesters starting at the pointer, first hit wins
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt_next = '0;
        winner   = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found         = 1'b1;
                gnt_next[idx] = 1'b1;
                winner        = idx;
            end
        end
    end

endmodule

// File: rtl/maze_job_scheduler.sv
// Shares one serial maze solver among NUM_REQ requesters: buffer a maze, replay it, tag results.
// Latency: feed starts 1 cycle after the last maze bit; each result beat trails its solver beat via a 1-deep hold.
// Backpressure: none on the solver side; requesters are held off by gnt until the job and its idle gap finish.
module maze_job_scheduler
    import maze_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAZE_BITS = MAZE_BITS_DEF,
    parameter int TIMEOUT   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic [NUM_REQ-1:0]         src_valid,
    input  logic [NUM_REQ-1:0]         src_bit,
    output logic                       slv_in_valid,
    output logic                       slv_in,
    input  logic                       slv_out_valid,
    input  logic [1:0]                 slv_out,
    output logic                       res_valid,
    output logic [1:0]                 res_dir,
    output logic                       res_last,
    output logic                       res_err,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAZE_BITS);
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(MAZE_BITS - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST  = ID_W'(NUM_REQ - 1);

    state_t                state, state_d;
    logic [MAZE_BITS-1:0]  maze_buf;
    logic [MAZE_BITS-1:0]  buf_ld;
    logic [BC_W-1:0]       bit_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [ID_W-1:0]       rr;
    dir_t                  hold;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]       arb_win;
    logic                  lane_vld;
    logic                  lane_bit;
    logic                  load_done;
    logic                  feed_done;
    logic                  timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .rr       (rr),
        .en       (state == S_IDLE),
        .gnt_next (arb_gnt),
        .winner   (arb_win)
    );

    // only the granted lane is looked at; gnt is one-hot or zero
    assign lane_vld  = |(src_valid & gnt);
    assign lane_bit  = |(src_bit & gnt);
    // bits enter at the MSB so the first-received bit ends up at index 0
    assign buf_ld    = {lane_bit, maze_buf[MAZE_BITS-1:1]};
    assign load_done = lane_vld && (bit_cnt == BIT_LAST);
    assign feed_done = (bit_cnt == BIT_LAST);
    assign timeout   = (to_cnt == TO_LAST);

    // next-state decode
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (|arb_gnt)          state_d = S_LOAD;
            S_LOAD:  if (load_done)         state_d = S_FEED;
            S_FEED:  if (feed_done)         state_d = S_WAIT;
            S_WAIT:  if (slv_out_valid)     state_d = S_DRAIN;
                     else if (timeout)      state_d = S_GAP;
            S_DRAIN: if (!slv_out_valid)    state_d = S_GAP;
            S_GAP:                          state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // maze buffer: shifts in during LOAD, shifts out during FEED; contents need no reset
    always_ff @(posedge clk) begin
        if (state == S_LOAD && lane_vld)
            maze_buf <= load_done ? {1'b0, buf_ld[MAZE_BITS-1:1]} : buf_ld;
        else if (state == S_FEED && !feed_done)
            maze_buf <= {1'b0, maze_buf[MAZE_BITS-1:1]};
    end

    // registered outputs, counters, rr pointer and result hold register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt          <= '0;
            res_id       <= '0;
            rr           <= '0;
            busy         <= 1'b0;
            slv_in_valid <= 1'b0;
            slv_in       <= 1'b0;
            res_valid    <= 1'b0;
            res_dir      <= '0;
            res_last     <= 1'b0;
            res_err      <= 1'b0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            hold         <= '0;
        end else begin
            busy      <= (state_d != S_IDLE);
            res_valid <= 1'b0;
            res_dir   <= '0;
            res_last  <= 1'b0;
            res_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|arb_gnt) begin
                        gnt     <= arb_gnt;
                        res_id  <= arb_win;
                        rr      <= (arb_win == ID_LAST) ? '0 : arb_win + ID_W'(1);
                        bit_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        bit_cnt      <= '0;
                        slv_in_valid <= 1'b1;
                        slv_in       <= buf_ld[0];
                    end else if (lane_vld) begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                S_FEED: begin
                    if (feed_done) begin
                        slv_in_valid <= 1'b0;
                        slv_in       <= 1'b0;
                        to_cnt       <= '0;
                    end else begin
                        slv_in  <= maze_buf[0];
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!timeout) to_cnt <= to_cnt + TO_W'(1);
                    if (slv_out_valid) begin
                        hold <= slv_out;
                    end else if (timeout) begin
                        res_valid <= 1'b1;
                        res_last  <= 1'b1;
                        res_err   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // a beat is last when the solver has nothing behind it
                    res_valid <= 1'b1;
                    res_dir   <= hold;
                    res_last  <= !slv_out_valid;
                    if (slv_out_valid) hold <= slv_out;
                end
                S_GAP: begin
                    gnt    <= '0;
                    res_id <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_job_scheduler.sv
module tb_maze_job_scheduler;

    localparam int NR = 4;
    localparam int MB = 289;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [NR-1:0] src_valid;
    logic [NR-1:0] src_bit;
    logic          slv_in_valid;
    logic          slv_in;
    logic          slv_out_valid;
    logic [1:0]    slv_out;
    logic          res_valid;
    logic [1:0]    res_dir;
    logic          res_last;
    logic          res_err;
    logic [1:0]    res_id;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit exp_bits [MB];

    maze_job_scheduler #(.NUM_REQ(NR), .MAZE_BITS(MB), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .gnt           (gnt),
        .src_valid     (src_valid),
        .src_bit       (src_bit),
        .slv_in_valid  (slv_in_valid),
        .slv_in        (slv_in),
        .slv_out_valid (slv_out_valid),
        .slv_out       (slv_out),
        .res_valid     (res_valid),
        .res_dir       (res_dir),
        .res_last      (res_last),
        .res_err       (res_err),
        .res_id        (res_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at an IDLE-cycle negedge right after req was driven
    task automatic wait_grant(input int lane, input string tag);
        int k = 0;
        while (gnt === '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, 1);
        chk({tag, "_gnt"}, gnt, 32'(1) << lane);
        chk({tag, "_id"}, res_id, lane);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // send MB random bits on the granted lane, noise on the other lanes
    task automatic load_maze(input int lane, input bit gaps);
        int bad = 0;
        logic [NR-1:0] m;
        m = NR'(1) << lane;
        for (int i = 0; i < MB; i++) begin
            exp_bits[i] = 1'($urandom_range(0, 1));
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    src_valid = NR'($urandom) & ~m;
                    src_bit   = NR'($urandom);
                    @(negedge clk);
                    if (slv_in_valid !== 1'b0) bad++;
                end
            end
            src_valid = (NR'($urandom) & ~m) | m;
            src_bit   = (NR'($urandom) & ~m) | (exp_bits[i] ? m : '0);
            @(negedge clk);
            if (i < MB - 1 && slv_in_valid !== 1'b0) bad++;
            if (gnt !== m) bad++;
        end
        src_valid = '0;
        src_bit   = '0;
        chk("load_quiet", bad, 0);
    endtask

    // first n feed cycles must be contiguous and carry the bits in arrival order
    task automatic feed_check(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (slv_in_valid !== 1'b1 || slv_in !== exp_bits[i] || res_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("feed_bits", bad, 0);
        if (n == MB) chk("feed_end", slv_in_valid, 0);
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_vld"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // solver answers with nbeats codes; each beat shows up two negedges after it is driven
    task automatic solver_reply(input int lane, input int nbeats, input logic [15:0] dirs);
        int bad = 0;
        repeat (3) begin
            if (res_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("wait_quiet", bad, 0);
        for (int t = 0; t < nbeats + 2; t++) begin
            slv_out_valid = (t < nbeats);
            slv_out       = (t < nbeats) ? dirs[2*t +: 2] : 2'b00;
            if (t >= 2) begin
                chk($sformatf("beat%0d_vld", t - 2), res_valid, 1);
                chk($sformatf("beat%0d_dir", t - 2), res_dir, dirs[2*(t-2) +: 2]);
                chk($sformatf("beat%0d_last", t - 2), res_last, (t - 2 == nbeats - 1) ? 1 : 0);
                chk($sformatf("beat%0d_err", t - 2), res_err, 0);
                chk($sformatf("beat%0d_id", t - 2), res_id, lane);
                chk($sformatf("beat%0d_gnt", t - 2), gnt, 32'(1) << lane);
            end else begin
                chk($sformatf("pre%0d_vld", t), res_valid, 0);
            end
            @(negedge clk);
        end
        idle_check("gap");
    endtask

    // solver silent: abort beat must appear TO cycles after slv_in_valid falls
    task automatic wait_timeout(input int lane);
        int k = 0;
        while (res_valid !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("to_lat", k, TO);
        chk("to_last", res_last, 1);
        chk("to_err", res_err, 1);
        chk("to_dir", res_dir, 0);
        chk("to_id", res_id, lane);
        chk("to_gnt", gnt, 32'(1) << lane);
        @(negedge clk);
        idle_check("to_gap");
    endtask

    initial begin
        rst           = 1'b1;
        req           = '0;
        src_valid     = '0;
        src_bit       = '0;
        slv_out_valid = 1'b0;
        slv_out       = 2'b00;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_vld", slv_in_valid, 0);
        chk("rst_in", slv_in, 0);
        chk("rst_res_vld", res_valid, 0);
        chk("rst_res_dir", res_dir, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_id", res_id, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // single job on lane 2 with src_valid gaps; req dropped during LOAD
        req = 4'b0100;
        wait_grant(2, "job2");
        req = 4'b0000;
        load_maze(2, 1'b1);
        feed_check(MB);
        solver_reply(2, 5, 16'({2'd1, 2'd3, 2'd2, 2'd1, 2'd0}));

        // single-beat result on lane 1
        req = 4'b0010;
        wait_grant(1, "job1");
        req = 4'b0000;
        load_maze(1, 1'b0);
        feed_check(MB);
        solver_reply(1, 1, 16'h0003);

        // timeout on lane 3
        req = 4'b1000;
        wait_grant(3, "job3");
        req = 4'b0000;
        load_maze(3, 1'b0);
        feed_check(MB);
        wait_timeout(3);

        // reset pulsed while feeding bit 100 of a lane 1 job
        req = 4'b0010;
        wait_grant(1, "jobr");
        req = 4'b0000;
        load_maze(1, 1'b0);
        feed_check(100);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_vld", slv_in_valid, 0);
        chk("mid_rst_in", slv_in, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_vld", res_valid, 0);
        chk("mid_rst_res_id", res_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // round robin with all requests held: 0,1,2,3,0
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(j % NR, $sformatf("rr%0d", j));
            load_maze(j % NR, 1'b0);
            feed_check(MB);
            wait_timeout(j % NR);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_gnt", gnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_job_scheduler.md
# maze_job_scheduler

Round-robin scheduler that shares one serial `MAZE` solver among `NUM_REQ` requesters. It collects a requester's maze bitmap into a local buffer and replays it to the solver as one gap-free `in_valid` burst. It then returns the solver's 2-bit direction stream tagged with the requester ID, and separates jobs with an idle gap. It sits between the requester fabric and the `MAZE` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAZE_BITS`, 289: bits per maze (17x17 map, row-major, serial).
- `TIMEOUT`, 4096: max cycles in WAIT with no solver output before abort.
- `ID_W`, `$clog2(NUM_REQ)`: width of requester ID (derived, not overridden).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester job request; held high until its `gnt` bit rises.
- `gnt`  out  NUM_REQ  one-hot grant; held from grant through the job's last result beat.
- `src_valid`  in  NUM_REQ  per-requester bit-valid; only the granted lane is sampled.
- `src_bit`  in  NUM_REQ  per-requester maze bit.
- `slv_in_valid`  out  1  to solver `in_valid`.
- `slv_in`  out  1  to solver `in`.
- `slv_out_valid`  in  1  from solver `out_valid`.
- `slv_out`  in  2  from solver `out`.
- `res_valid`  out  1  result beat valid.
- `res_dir`  out  2  direction code, passed through unchanged.
- `res_last`  out  1  final beat of the job.
- `res_err`  out  1  timeout abort; only with `res_valid & res_last`, `res_dir`=0.
- `res_id`  out  ID_W  index of the granted requester.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, LOAD, FEED, WAIT, DRAIN, GAP.
- **IDLE:**
  - If `req` != 0, a round-robin pick starts from pointer `rr`.
  - Winner's `gnt` bit is set and `res_id` = winner, both registered. Go to LOAD.
  - `rr` = winner+1, wrapping at `NUM_REQ`.
- **LOAD:**
  - Each cycle with the granted lane's `src_valid`=1, its `src_bit` shifts into a `MAZE_BITS` buffer and `bit_cnt` increments.
  - Gaps in `src_valid` are allowed.
  - When `bit_cnt` reaches `MAZE_BITS`-1 with a valid bit, go to FEED.
  - `src_valid` on non-granted lanes is ignored.
- **FEED:**
  - `slv_in_valid`=1 for exactly `MAZE_BITS` consecutive cycles.
  - `slv_in` = buffer bits in arrival order, first-received bit first.
  - Then go to WAIT with `to_cnt` cleared.
- **WAIT:**
  - `to_cnt` increments each cycle.
  - On `slv_out_valid`=1, capture `slv_out` into the hold register and go to DRAIN.
  - If `to_cnt` reaches `TIMEOUT`-1, emit one beat with `res_valid`=`res_last`=`res_err`=1, then go to GAP.
- **DRAIN:**
  - Each cycle, the hold register is emitted as a result beat.
  - `res_last`=1 when `slv_out_valid`=0 in that cycle.
  - If `slv_out_valid`=1, it is captured as the next hold value.
  - After the last beat, go to GAP.
- **GAP:**
  - One cycle with `gnt`=0 and all solver and result outputs low. Go to IDLE.
- **Requester behaviour:**
  - `req` deasserting while granted is ignored; the job completes.
  - A new `req` on the granted lane is arbitrated only after GAP.
- **Counter widths:** `bit_cnt` = `$clog2(MAZE_BITS)`; `to_cnt` = `$clog2(TIMEOUT)`. Neither wraps; each clears on state entry.
- **Reset:** any state returns to IDLE. Buffer contents are don't-care.

## Timing
- **Reset values:**
  - `gnt`=0, `busy`=0.
  - `slv_in_valid`=0, `slv_in`=0.
  - `res_valid`=`res_dir`=`res_last`=`res_err`=0, `res_id`=0.
  - `rr`=0.
- **Arbitration:** `req` sampled in IDLE at edge N; `gnt` and `busy` high after edge N.
- **Load to feed:** last valid bit sampled at edge M; first `slv_in_valid` cycle is M+1.
- **Result latency:** each result beat appears exactly 1 cycle after its `slv_out_valid` sample. Result beat count equals solver beat count.
- **Job end:**
  - `gnt` falls on the edge after the `res_last` beat.
  - Minimum 1 idle cycle between the last result beat and the next `gnt`.
- **Outputs:** all registered; no combinational input-to-output paths.

## Structure
- **Package `maze_pkg`:**
  - State enum.
  - `MAZE_BITS` default.
  - 2-bit direction typedef and codes.
- **Sub-module `rr_arbiter`:** parameterised by `NUM_REQ`; inputs `req`, `rr` pointer, `en`; outputs one-hot `gnt_next` and winner index.
- **Top level:** FSM, buffer, counters and result pipeline stay in the top.

## Test plan
- **Single job:**
  - Stimulus: requester 2 sends 289 bits with random `src_valid` gaps; solver model returns 5 beats.
  - Response: exactly 289 contiguous `slv_in_valid` cycles with bit order preserved; 5 result beats with `res_id`=2, `res_last` on beat 5, `gnt`=4'b0100 throughout.
- **Round robin:**
  - Stimulus: `req`=4'b1111 held.
  - Response: grant order 0,1,2,3,0, each separated by one GAP cycle.
- **Timeout:**
  - Stimulus: solver never responds, `TIMEOUT`=16.
  - Response: single beat with `res_valid`=`res_last`=`res_err`=1 exactly 16 cycles after FEED ends; next grant after GAP.
- **Single-beat result:**
  - Stimulus: one-cycle `slv_out_valid` with `slv_out`=2'b11.
  - Response: one beat with `res_dir`=3, `res_last`=1.
- **Reset mid-operation:**
  - Stimulus: `rst` pulsed during FEED at bit 100.
  - Response: `slv_in_valid` drops immediately; all outputs at reset values; next job starts at requester 0.
- **Request drop:**
  - Stimulus: granted requester drops `req` during LOAD.
  - Response: job continues and completes normally.
